// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the sequence-pair scheduler
package seq_pkg;

    localparam int DEF_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_S1   = 2'd1;
    localparam logic [1:0] MODE_S2   = 2'd2;
    localparam logic [1:0] MODE_BOTH = 2'd3;

endpackage

// File: rtl/seq_pair_sched_if.sv
// rtl/seq_pair_sched_if.sv - host, checker and report signals of the scheduler
interface seq_pair_sched_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word1;
    logic [WORD_W-1:0] in_word2;
    logic              seq1;
    logic              seq2;
    logic              det_en;
    logic [1:0]        mode;
    logic [3:0]        result;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  cnt_m1;
    logic [CNT_W-1:0]  cnt_m2;
    logic [CNT_W-1:0]  cnt_m3;
    logic [3:0]        last_result;
    logic              busy;

    modport master (
        output in_valid, in_word1, in_word2, mode, result, out_ready,
        input  in_ready, seq1, seq2, det_en, out_valid,
               cnt_m1, cnt_m2, cnt_m3, last_result, busy
    );

    modport slave (
        input  in_valid, in_word1, in_word2, mode, result, out_ready,
        output in_ready, seq1, seq2, det_en, out_valid,
               cnt_m1, cnt_m2, cnt_m3, last_result, busy
    );
endinterface

// File: rtl/mode_tally.sv
// rtl/mode_tally.sv - saturating per-mode counters and last sampled result
module mode_tally
    import seq_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [1:0]       mode,
    input  logic [3:0]       result,
    output logic [CNT_W-1:0] cnt_m1,
    output logic [CNT_W-1:0] cnt_m2,
    output logic [CNT_W-1:0] cnt_m3,
    output logic [3:0]       last_result
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_m1      <= '0;
            cnt_m2      <= '0;
            cnt_m3      <= '0;
            last_result <= '0;
        end else if (clr) begin
            cnt_m1      <= '0;
            cnt_m2      <= '0;
            cnt_m3      <= '0;
            last_result <= '0;
        end else if (sample_en) begin
            last_result <= result;
            case (mode)
                MODE_NONE: ;
                MODE_S1:   if (cnt_m1 != CNT_MAX) cnt_m1 <= cnt_m1 + 1'b1;
                MODE_S2:   if (cnt_m2 != CNT_MAX) cnt_m2 <= cnt_m2 + 1'b1;
                MODE_BOTH: if (cnt_m3 != CNT_MAX) cnt_m3 <= cnt_m3 + 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/seq_pair_sched.sv
// rtl/seq_pair_sched.sv - serialises word pairs into the checker and reports mode tallies
module seq_pair_sched
    import seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DRAIN  = 1,
    parameter int CNT_W  = 6
) (
    input logic             clk,
    input logic             rst,
    seq_pair_sched_if.slave bus
);

    localparam int BC_W = $clog2(WORD_W) + 1;
    localparam int DR_W = $clog2(DRAIN) + 1;
    localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(WORD_W - 1);
    localparam logic [DR_W-1:0] LAST_DRAIN = DR_W'(DRAIN - 1);

    state_t            state;
    logic [WORD_W-1:0] sr1;
    logic [WORD_W-1:0] sr2;
    logic [BC_W-1:0]   bit_cnt;
    logic [DR_W-1:0]   drain_cnt;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              det_en_r;
    logic              busy_r;
    logic              accept;
    logic              sample_en;
    logic [CNT_W-1:0]  t_m1;
    logic [CNT_W-1:0]  t_m2;
    logic [CNT_W-1:0]  t_m3;
    logic [3:0]        t_last;

    assign accept = (state == ST_IDLE) && in_ready_r && bus.in_valid;

    // The first SHIFT cycle is skipped: the checker has not yet seen a bit.
    assign sample_en = ((state == ST_SHIFT) && (bit_cnt != '0)) || (state == ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sr1         <= '0;
            sr2         <= '0;
            bit_cnt     <= '0;
            drain_cnt   <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            det_en_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_SHIFT;
                        sr1        <= bus.in_word1;
                        sr2        <= bus.in_word2;
                        bit_cnt    <= '0;
                        in_ready_r <= 1'b0;
                        det_en_r   <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    sr1     <= {sr1[WORD_W-2:0], 1'b0};
                    sr2     <= {sr2[WORD_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state     <= ST_DRAIN;
                        det_en_r  <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state       <= ST_REPORT;
                        out_valid_r <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mode_tally #(.CNT_W(CNT_W)) u_tally (
        .clk         (clk),
        .rst         (rst),
        .clr         (accept),
        .sample_en   (sample_en),
        .mode        (bus.mode),
        .result      (bus.result),
        .cnt_m1      (t_m1),
        .cnt_m2      (t_m2),
        .cnt_m3      (t_m3),
        .last_result (t_last)
    );

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.det_en      = det_en_r;
    assign bus.busy        = busy_r;
    assign bus.seq1        = det_en_r & sr1[WORD_W-1];
    assign bus.seq2        = det_en_r & sr2[WORD_W-1];
    assign bus.cnt_m1      = t_m1;
    assign bus.cnt_m2      = t_m2;
    assign bus.cnt_m3      = t_m3;
    assign bus.last_result = t_last;

endmodule

// File: doc/seq_pair_sched.md
# seq_pair_sched

Controller that sequences the two-stream sequence detector/checker datapath. It accepts a pair of parallel words over a valid/ready handshake and shifts them MSB-first onto the checker's `seq1`/`seq2` serial inputs, one bit per clock. It samples the checker's `mode`/`result` outputs and tallies how often each non-zero `mode` occurred, then presents a summary over a second valid/ready handshake. It sits between a host/stimulus source and the checker top level, replacing free-running shift registers.

## Interface
Parameters:
- `WORD_W`, 32: bits per stream word.
- `DRAIN`, 1: idle cycles after the last bit, covering checker output latency (≥1).
- `CNT_W`, 6: tally counter width; counters saturate.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  word pair offered.
- `in_ready`  out  1  controller can accept a pair.
- `in_word1`  in  WORD_W  stream 1 word; bit WORD_W-1 is sent first.
- `in_word2`  in  WORD_W  stream 2 word.
- `seq1`  out  1  serial bit to checker stream 1.
- `seq2`  out  1  serial bit to checker stream 2.
- `det_en`  out  1  high while `seq1`/`seq2` carry valid bits.
- `mode`  in  2  checker mode: 0 none, 1 seq1 hit, 2 seq2 hit, 3 both.
- `result`  in  4  checker result.
- `out_valid`  out  1  summary available.
- `out_ready`  in  1  summary consumer ready.
- `cnt_m1`, `cnt_m2`, `cnt_m3`  out  CNT_W each  count of sampled cycles with mode 1, 2 and 3.
- `last_result`  out  4  `result` at the final sample.
- `busy`  out  1  state ≠ IDLE.

## Operation
FSM states are IDLE, SHIFT, DRAIN and REPORT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: load both shift registers, clear the counters and `last_result`, set bit count 0, and go to SHIFT.
- **SHIFT**
  - `seq1`/`seq2` = MSB of each shift register; `det_en`=1.
  - Each cycle: shift left by one (zero fill) and increment the bit count.
  - After the cycle presenting the WORD_W-th bit, go to DRAIN.
- **DRAIN**
  - `seq1`=`seq2`=`det_en`=0.
  - Lasts exactly DRAIN cycles, then go to REPORT.
- **REPORT**
  - `out_valid`=1; counters and `last_result` are held stable.
  - On `out_valid && out_ready`, go to IDLE.

Sampling:
- The sample window is every cycle of SHIFT except the first, plus every DRAIN cycle: (WORD_W−1+DRAIN) samples.
- Per sample, mode 1/2/3 increments `cnt_m1`/`cnt_m2`/`cnt_m3`; mode 0 increments nothing.
- Counters saturate at 2^CNT_W−1.
- `last_result` is updated on every sample, so it ends up holding the final sample's value.

Boundary rules:
- `in_ready` is low in SHIFT, DRAIN and REPORT, so an offered pair stalls until IDLE.
- `in_word*` are ignored outside the accepting edge.
- `out_ready` high outside REPORT has no effect.
- Reset at any time, including mid-SHIFT: every register clears immediately and the partial word is discarded.

## Timing
- Reset values: `in_ready`=0 while `rst`=1, then 1 after release (state IDLE). `seq1`=`seq2`=`det_en`=0, `out_valid`=0, all counts 0, `last_result`=0, `busy`=0.
- Input handshake at edge k:
  - Cycle k+1 presents bit WORD_W−1.
  - Cycle k+n presents bit WORD_W−n, for n=1..WORD_W.
- DRAIN occupies cycles k+WORD_W+1 … k+WORD_W+DRAIN.
- `out_valid` rises in cycle k+WORD_W+DRAIN+1.
- Output handshake at edge j: IDLE (`in_ready`=1) in cycle j+1. Minimum acceptance period is WORD_W+DRAIN+2 cycles.
- `in_ready`, `out_valid`, `busy` and `det_en` decode state only; there is no combinational path from inputs.

## Structure
- Shared package `seq_pkg`:
  - state enum (IDLE/SHIFT/DRAIN/REPORT);
  - mode encoding constants `MODE_NONE`=0, `MODE_S1`=1, `MODE_S2`=2, `MODE_BOTH`=3;
  - default `WORD_W`.
- Sub-module `mode_tally`:
  - three saturating CNT_W counters plus the `last_result` register;
  - inputs: `clr`, `sample_en`, `mode`, `result`.
- The FSM, bit counter (width $clog2(WORD_W)+1) and the two shift registers stay in the top module.

## Test plan
- **Serialization:** `in_word1`=0x8BF8BDB1, `in_word2`=0xBBF8AEB1. Expect `seq1` over cycles k+1..k+32 to read 1,0,0,0,1,0,1,1,…,0,0,0,1; likewise for `seq2`. `det_en` is high for exactly 32 cycles.
- **Constant mode:** bench model drives `mode`=3 and `result`=5 throughout (DRAIN=1). Expect `cnt_m3`=32, `cnt_m1`=`cnt_m2`=0, `last_result`=5, `out_valid` in cycle k+34.
- **Mixed modes:** `mode`=1 for the first 10 samples, 2 for the next 5, then 0. Expect `cnt_m1`=10, `cnt_m2`=5, `cnt_m3`=0.
- **Saturation:** CNT_W=4, `mode`=1 throughout. Expect `cnt_m1`=15.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in REPORT. Outputs stay stable and `in_ready`=0; when `out_ready`=1, `in_ready`=1 the next cycle, and a pair pending on `in_valid` is accepted then.
- **Reset mid-SHIFT:** assert `rst` at bit 10. All outputs drop to reset values asynchronously. After release, `in_ready`=1 and a fresh pair shifts from its MSB.
